// File: rtl/req_pending_latch.sv
// Request capture stage: synchronises async request lines, latches rising edges as sticky
// pending bits and offers the encoder's winning index to a servicer over valid/ready.
module req_pending_latch #(
   parameter int unsigned N           = 4,
   parameter int unsigned IW          = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_in,
   input  logic [N-1:0]  mask_in,
   output logic [N-1:0]  pend_out,
   input  logic [IW-1:0] idx_in,
   input  logic          idx_valid_in,
   output logic          srv_valid_out,
   output logic [IW-1:0] srv_idx_out,
   input  logic          srv_ready_in,
   output logic [N-1:0]  ovf_out,
   input  logic [N-1:0]  ovf_clr_in
);

   typedef enum logic [0:0] {StIdle, StOffer} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  sync_q [SYNC_STAGES];
   logic [N-1:0]  prev_q;
   logic [N-1:0]  pend_q, pend_d;
   logic [N-1:0]  ovf_q, ovf_d;
   logic [IW-1:0] srv_idx_q, srv_idx_d;
   logic [N-1:0]  rise;
   logic [N-1:0]  clr;
   logic          accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
         prev_q    <= '0;
         pend_q    <= '0;
         ovf_q     <= '0;
         srv_idx_q <= '0;
         state_q   <= StIdle;
      end else begin
         sync_q[0] <= req_in;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q    <= sync_q[SYNC_STAGES-1];
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         srv_idx_q <= srv_idx_d;
         state_q   <= state_d;
      end
   end

   assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign accept = (state_q == StOffer) && srv_ready_in;

   always_comb begin
      clr = '0;
      if (accept) begin
         clr[srv_idx_q] = 1'b1;
      end
   end

   // Set beats clear in both vectors; a rise on a line being cleared is a fresh event.
   always_comb begin
      pend_d = (pend_q & ~clr) | rise;
      ovf_d  = (ovf_q & ~ovf_clr_in) | (rise & pend_q & ~clr);
   end

   always_comb begin
      state_d   = state_q;
      srv_idx_d = srv_idx_q;
      unique case (state_q)
         StIdle: begin
            if (idx_valid_in) begin
               srv_idx_d = idx_in;
               state_d   = StOffer;
            end
         end
         StOffer: begin
            if (srv_ready_in) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign pend_out      = pend_q & mask_in;
   assign ovf_out       = ovf_q;
   assign srv_valid_out = (state_q == StOffer);
   assign srv_idx_out   = srv_idx_q;

endmodule

// File: tb/tb_req_pending_latch.sv
// Scoreboard bench for req_pending_latch with a highest-index-wins encoder model in the loop.
module tb_req_pending_latch;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_in, mask_in, pend_out, ovf_out, ovf_clr_in;
   logic [IW-1:0] idx_in, srv_idx_out;
   logic          idx_valid_in, srv_valid_out, srv_ready_in;

   int total = 0;
   int bad   = 0;
   logic [IW-1:0] exp_q [$];

   req_pending_latch #(.N(N), .IW(IW), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_in        (req_in),
      .mask_in       (mask_in),
      .pend_out      (pend_out),
      .idx_in        (idx_in),
      .idx_valid_in  (idx_valid_in),
      .srv_valid_out (srv_valid_out),
      .srv_idx_out   (srv_idx_out),
      .srv_ready_in  (srv_ready_in),
      .ovf_out       (ovf_out),
      .ovf_clr_in    (ovf_clr_in)
   );

   always #5 clk = ~clk;

   // Encoder model: highest set bit wins.
   always_comb begin
      idx_in       = '0;
      idx_valid_in = |pend_out;
      for (int i = 0; i < N; i++) begin
         if (pend_out[i]) idx_in = IW'(i);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted offer must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && srv_valid_out === 1'b1 && srv_ready_in === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_offer: got idx %0d want no offer at %0t", srv_idx_out, $time);
         end else begin
            check("offer_idx", 32'(srv_idx_out), 32'(exp_q.pop_front()));
         end
      end
   end

   // Inputs change and outputs are checked 1 time unit after each rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; req_in = '0; mask_in = 4'hF; ovf_clr_in = '0; srv_ready_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(srv_valid_out), 0);
      check("rst_idx", 32'(srv_idx_out), 0);
      check("rst_pend", 32'(pend_out), 0);
      check("rst_ovf", 32'(ovf_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(2);

      // Single request on line 2
      srv_ready_in = 1'b1;
      req_in = 4'b0100; exp_q.push_back(2'd2);
      tick(2);
      check("single_valid_e1", 32'(srv_valid_out), 0);
      tick();
      check("single_pend_e2", 32'(pend_out), 32'h4);
      check("single_valid_e2", 32'(srv_valid_out), 0);
      tick();
      check("single_valid_e3", 32'(srv_valid_out), 1);
      check("single_idx_e3", 32'(srv_idx_out), 2);
      tick();
      check("single_pend_after", 32'(pend_out), 0);
      check("single_valid_after", 32'(srv_valid_out), 0);
      tick(6);
      check("single_no_reoffer", 32'(srv_valid_out), 0);
      req_in = '0;
      tick(4);

      // Priority drain of lines 0, 1, 3
      req_in = 4'b1011;
      exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      tick(3);
      check("drain_pend0", 32'(pend_out), 32'hB);
      tick();
      check("drain_idx3", 32'(srv_idx_out), 3);
      tick();
      check("drain_pend1", 32'(pend_out), 32'h3);
      check("drain_gap", 32'(srv_valid_out), 0);
      tick();
      check("drain_idx1", 32'(srv_idx_out), 1);
      tick();
      check("drain_pend2", 32'(pend_out), 32'h1);
      tick();
      check("drain_idx0", 32'(srv_idx_out), 0);
      tick();
      check("drain_pend3", 32'(pend_out), 0);
      req_in = '0;
      tick(4);

      // Stall with a higher-priority rise during the open offer
      srv_ready_in = 1'b0;
      req_in = 4'b0001;
      exp_q.push_back(2'd0); exp_q.push_back(2'd3);
      tick(4);
      check("stall_valid", 32'(srv_valid_out), 1);
      req_in = 4'b1001;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_hold_valid", 32'(srv_valid_out), 1);
         check("stall_hold_idx", 32'(srv_idx_out), 0);
      end
      srv_ready_in = 1'b1;
      tick();
      check("stall_gap", 32'(srv_valid_out), 0);
      tick();
      check("stall_next_idx", 32'(srv_idx_out), 3);
      check("stall_next_valid", 32'(srv_valid_out), 1);
      tick();
      req_in = '0;
      tick(4);

      // Overflow: two pulses on line 1 before service
      srv_ready_in = 1'b0;
      exp_q.push_back(2'd1);
      req_in = 4'b0010; tick(2);
      req_in = 4'b0000; tick(2);
      req_in = 4'b0010; tick(2);
      req_in = 4'b0000; tick(4);
      check("ovf_flag", 32'(ovf_out), 32'h2);
      check("ovf_pend", 32'(pend_out), 32'h2);
      check("ovf_idx", 32'(srv_idx_out), 1);
      srv_ready_in = 1'b1;
      tick(4);
      check("ovf_pend_cleared", 32'(pend_out), 0);
      check("ovf_still_set", 32'(ovf_out), 32'h2);
      ovf_clr_in = 4'b0010; tick();
      ovf_clr_in = '0;
      check("ovf_cleared", 32'(ovf_out), 0);

      // Rise coinciding with acceptance of line 1
      srv_ready_in = 1'b0;
      exp_q.push_back(2'd1); exp_q.push_back(2'd1);
      req_in = 4'b0010; tick(2);
      req_in = 4'b0000; tick(4);
      check("coin_offer", 32'(srv_valid_out), 1);
      req_in = 4'b0010; tick(2);
      srv_ready_in = 1'b1;
      tick();
      check("coin_pend_reset", 32'(pend_out), 32'h2);
      check("coin_no_ovf", 32'(ovf_out), 0);
      req_in = '0;
      tick();
      check("coin_reoffer", 32'(srv_valid_out), 1);
      tick(2);
      check("coin_drained", 32'(pend_out), 0);
      tick(3);

      // Masked line 0
      mask_in = 4'b1110;
      req_in  = 4'b0001;
      tick(6);
      check("mask_pend", 32'(pend_out), 0);
      check("mask_no_offer", 32'(srv_valid_out), 0);
      mask_in = 4'b1111;
      exp_q.push_back(2'd0);
      #1;
      check("unmask_pend", 32'(pend_out), 32'h1);
      tick();
      check("unmask_offer", 32'(srv_valid_out), 1);
      check("unmask_idx", 32'(srv_idx_out), 0);
      tick();
      req_in = '0;
      tick(4);

      // Reset during an open offer, with an overflow on line 2
      srv_ready_in = 1'b0;
      req_in = 4'b1100; tick(2);
      req_in = 4'b1000; tick(2);
      req_in = 4'b1100; tick(2);
      req_in = 4'b1000; tick(4);
      check("prerst_valid", 32'(srv_valid_out), 1);
      check("prerst_idx", 32'(srv_idx_out), 3);
      check("prerst_ovf", 32'(ovf_out), 32'h4);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(srv_valid_out), 0);
      check("midrst_pend", 32'(pend_out), 0);
      check("midrst_ovf", 32'(ovf_out), 0);
      tick(2);
      rst_n = 1'b1;
      exp_q.push_back(2'd3);
      tick(2);
      check("postrst_valid_e1", 32'(srv_valid_out), 0);
      tick();
      check("postrst_pend", 32'(pend_out), 32'h8);
      tick();
      check("postrst_valid_e3", 32'(srv_valid_out), 1);
      check("postrst_idx", 32'(srv_idx_out), 3);
      srv_ready_in = 1'b1;
      tick(4);
      req_in = '0;
      tick(4);

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/req_pending_latch.md
# req_pending_latch

Request capture and service stage directly upstream of `priEncoder`. It synchronises four asynchronous request lines, detects rising edges, and holds each event as a sticky pending bit. The masked pending vector drives the encoder's `data_in`. The encoder's `y_out`/`data_valid` come back into this block, which offers the winning index to a downstream servicer through a valid/ready handshake and clears that pending bit once the index is accepted.

## Interface
- `N`, 4: number of request lines; equals encoder `data_in` width.
- `IW`, 2: index width, equals `$clog2(N)`.
- `SYNC_STAGES`, 2: synchroniser depth per request line; legal values are 2 or more.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req_in` input N: asynchronous request levels, one per line.
- `mask_in` input N: 1 = line enabled for presentation. Registered-domain input.
- `pend_out` output N: `pending & mask_in`, combinational; connects to encoder `data_in`.
- `idx_in` input IW: encoder `y_out`.
- `idx_valid_in` input 1: encoder `data_valid`.
- `srv_valid_out` output 1: service offer valid.
- `srv_idx_out` output IW: offered index; held stable while the offer is open.
- `srv_ready_in` input 1: servicer accepts the offer.
- `ovf_out` output N: sticky per-line overflow flags.
- `ovf_clr_in` input N: per-line overflow clear, one-cycle pulse.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per line, all reset to 0.
- **Edge detector:** a rise is `sync & ~prev`, with `prev` reset to 0. A line held high through reset release therefore produces one rise.
- **Pending bit `i`:**
  - Set on a rise on line `i`.
  - Cleared on handshake acceptance of index `i`.
  - If a rise and a clear of the same line land in the same cycle, set wins and `ovf_out[i]` is not set.
- **Masking:** masked lines still latch rises and overflows; they are only hidden from `pend_out`.
- **Overflow:** a rise on line `i` while `pending[i]` is 1 and line `i` is not being cleared that cycle sets `ovf_out[i]`.
  - The flag stays set until `ovf_clr_in[i]`.
  - If a set and a clear coincide, set wins.
- **FSM, two states: IDLE and OFFER.**
  - IDLE: `srv_valid_out = 0`. When `idx_valid_in = 1`, capture `idx_in` into `srv_idx_out` and go to OFFER.
  - OFFER: `srv_valid_out = 1`. When `srv_ready_in = 1`, clear `pending[srv_idx_out]` and return to IDLE.
  - The IDLE cycle after every acceptance lets the encoder re-evaluate from the updated `pend_out`.
- **Offer stability:** once in OFFER, the offer is never retracted. Changes to `mask_in` or `pend_out` do not alter `srv_idx_out`.
- **Reset values:** `pending`, `ovf_out`, and all sync/prev flops are 0; FSM is in IDLE; `srv_valid_out = 0`; `srv_idx_out = 0`; `pend_out = 0`.

## Timing
- Let cycle 0 be the first clock edge at which `req_in[i]` is sampled high.
  - `pending[i]` is set at edge `SYNC_STAGES`.
  - `pend_out[i]` rises after that edge; `idx_valid_in` follows combinationally through the encoder.
  - FSM enters OFFER at edge `SYNC_STAGES+1`.
  - `srv_valid_out` is high from edge `SYNC_STAGES+1`: 3 cycles after sampling with the default depth.
- **Acceptance:** at the edge where `srv_valid_out & srv_ready_in`, `pending` clears and the FSM moves to IDLE.
  - Earliest next offer is 2 edges after acceptance.
  - Maximum service rate is 1 index per 2 cycles.
- `srv_ready_in` asserted while `srv_valid_out = 0` has no effect.
- Back-to-back rises on one line must be at least 2 cycles apart after synchronisation to be distinct events; faster toggling may merge.
- Asserting `rst_n` low mid-offer drops `srv_valid_out` asynchronously and discards all pending events and overflows.

## Test plan
- **Single request:** reset, `mask_in = 4'hF`, raise `req_in[2]` and hold, `srv_ready_in = 1` → `srv_valid_out` high exactly 3 cycles after first sample with `srv_idx_out = 2`. `pend_out` returns to 0 the cycle after acceptance, and there is no re-offer while `req_in[2]` stays high.
- **Priority drain:** rise on lines 0, 1, 3 together, `srv_ready_in = 1` → offers arrive in encoder priority order (3, 1, 0), 2 cycles apart. `pend_out` goes `4'b1011` → `4'b0011` → `4'b0001` → `4'b0000`.
- **Stall and stability:** offer open with `srv_ready_in = 0` for 5 cycles while a higher-priority line rises → `srv_idx_out` is unchanged for all 5 cycles. After acceptance, the new line is offered next.
- **Overflow:** pulse line 1 twice before servicing → `ovf_out[1] = 1`, `pending[1]` stays 1, and only one offer is made. `ovf_clr_in[1]` pulse → `ovf_out[1] = 0`. A rise coinciding with the acceptance of line 1 → pending re-sets and `ovf_out[1]` stays 0.
- **Mask:** `mask_in = 4'b1110`, rise on line 0 → `pend_out = 0` and no offer. Set `mask_in[0] = 1` → `pend_out = 4'b0001`, and the offer of index 0 follows 1 cycle later.
- **Reset mid-operation:** deassert `rst_n` during an open offer with `req_in[3]` held high → `srv_valid_out = 0` immediately and `pending`/`ovf_out` are all 0. After release, line 3 is re-detected and offered `SYNC_STAGES+1` cycles later.
